// File: rtl/cryptoprocessor_seq.sv
// Command-sequenced carry-save register file in front of the external add/sub/mul+red units.
// One command is in flight at a time; results are written back before the next command reads the RF.
module cryptoprocessor_seq #(
  parameter  int WIDTH      = 1506,
  parameter  int DEPTH      = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int CMD_W      = 3 + 3 * ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd_in,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_s,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout_c,
  output logic [WIDTH-1:0] dout_s,
  output logic             dout_valid,
  output logic [WIDTH-1:0] op1_c,
  output logic [WIDTH-1:0] op1_s,
  output logic [WIDTH-1:0] op2_c,
  output logic [WIDTH-1:0] op2_s,
  output logic [1:0]       unit_sel,
  output logic             unit_start,
  input  logic [WIDTH-1:0] add_o_c,
  input  logic [WIDTH-1:0] add_o_s,
  input  logic [WIDTH-1:0] sub_o_c,
  input  logic [WIDTH-1:0] sub_o_s,
  input  logic [WIDTH-1:0] red_o_c,
  input  logic [WIDTH-1:0] red_o_s,
  input  logic             unit_done,
  output logic             busy,
  output logic             err
);

  localparam int FPTR_W = $clog2(FIFO_DEPTH);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_READ = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WB, S_LOAD_WAIT, S_RD
  } state_t;

  state_t state_q, state_d;

  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CMD_W-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [FPTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FPTR_W:0]   count_q, count_d;

  logic [WIDTH-1:0] rf_c_q [DEPTH];
  logic [WIDTH-1:0] rf_s_q [DEPTH];

  logic [WIDTH-1:0] op1_c_q, op1_c_d, op1_s_q, op1_s_d;
  logic [WIDTH-1:0] op2_c_q, op2_c_d, op2_s_q, op2_s_d;
  logic [WIDTH-1:0] dout_c_q, dout_c_d, dout_s_q, dout_s_d;
  logic [WIDTH-1:0] res_c_q, res_c_d, res_s_q, res_s_d;
  logic [1:0]       unit_sel_q, unit_sel_d;
  logic             err_q, err_d;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wc, rf_ws;

  logic              fifo_full, fifo_empty, push, pop;
  logic [2:0]        cur_op;
  logic [ADDR_W-1:0] cur_dst, cur_srca, cur_srcb;

  assign cur_op   = cmd_q[CMD_W-1 -: 3];
  assign cur_dst  = cmd_q[3*ADDR_W-1 -: ADDR_W];
  assign cur_srca = cmd_q[2*ADDR_W-1 -: ADDR_W];
  assign cur_srcb = cmd_q[ADDR_W-1:0];

  // Ready is held low during reset so nothing is accepted until the FIFO is flushed.
  assign fifo_full  = (count_q == (FPTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign cmd_ready  = !fifo_full && !rst;
  assign push       = cmd_valid && cmd_ready;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;

  assign din_ready  = (state_q == S_LOAD_WAIT);
  assign dout_valid = (state_q == S_RD);
  assign unit_start = (state_q == S_ISSUE);
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  assign dout_c   = dout_c_q;
  assign dout_s   = dout_s_q;
  assign op1_c    = op1_c_q;
  assign op1_s    = op1_s_q;
  assign op2_c    = op2_c_q;
  assign op2_s    = op2_s_q;
  assign unit_sel = unit_sel_q;
  assign err      = err_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op1_c_d    = op1_c_q;
    op1_s_d    = op1_s_q;
    op2_c_d    = op2_c_q;
    op2_s_d    = op2_s_q;
    dout_c_d   = dout_c_q;
    dout_s_d   = dout_s_q;
    res_c_d    = res_c_q;
    res_s_d    = res_s_q;
    unit_sel_d = unit_sel_q;
    err_d      = err_q;
    rf_we      = 1'b0;
    rf_waddr   = cur_dst;
    rf_wc      = res_c_q;
    rf_ws      = res_s_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          cmd_d   = fifo_mem_q[rd_ptr_q];
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        op1_c_d = rf_c_q[cur_srca];
        op1_s_d = rf_s_q[cur_srca];
        op2_c_d = rf_c_q[cur_srcb];
        op2_s_d = rf_s_q[cur_srcb];
        case (cur_op)
          OP_LOAD: state_d = S_LOAD_WAIT;
          OP_ADD: begin
            unit_sel_d = 2'd0;
            state_d    = S_ISSUE;
          end
          OP_SUB: begin
            unit_sel_d = 2'd1;
            state_d    = S_ISSUE;
          end
          OP_MUL: begin
            unit_sel_d = 2'd2;
            state_d    = S_ISSUE;
          end
          OP_READ: begin
            dout_c_d = rf_c_q[cur_srca];
            dout_s_d = rf_s_q[cur_srca];
            state_d  = S_RD;
          end
          OP_NOP:  state_d = S_IDLE;
          default: begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (unit_done) begin
          case (unit_sel_q)
            2'd0: begin
              res_c_d = add_o_c;
              res_s_d = add_o_s;
            end
            2'd1: begin
              res_c_d = sub_o_c;
              res_s_d = sub_o_s;
            end
            default: begin
              res_c_d = red_o_c;
              res_s_d = red_o_s;
            end
          endcase
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_IDLE;
      end
      S_LOAD_WAIT: begin
        if (din_valid) begin
          rf_we   = 1'b1;
          rf_wc   = din_c;
          rf_ws   = din_s;
          state_d = S_IDLE;
        end
      end
      S_RD:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op1_c_q    <= '0;
      op1_s_q    <= '0;
      op2_c_q    <= '0;
      op2_s_q    <= '0;
      dout_c_q   <= '0;
      dout_s_q   <= '0;
      res_c_q    <= '0;
      res_s_q    <= '0;
      unit_sel_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op1_c_q    <= op1_c_d;
      op1_s_q    <= op1_s_d;
      op2_c_q    <= op2_c_d;
      op2_s_q    <= op2_s_d;
      dout_c_q   <= dout_c_d;
      dout_s_q   <= dout_s_d;
      res_c_q    <= res_c_d;
      res_s_q    <= res_s_d;
      unit_sel_q <= unit_sel_d;
      err_q      <= err_d;
    end
  end

  // Storage arrays carry no reset; the RF deliberately survives rst, only the write is blocked.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= cmd_in;
    end
    if (rf_we && !rst) begin
      rf_c_q[rf_waddr] <= rf_wc;
      rf_s_q[rf_waddr] <= rf_ws;
    end
  end

endmodule
